clint_trap_ctrl: RTL and testbench
==================================

Name: clint_trap_ctrl

Overview:
Parametrised machine-mode trap controller that sits between ID/EX and csr_regs.
- Arbitrates synchronous exceptions (ECALL/EBREAK), MRET and asynchronous interrupts. Interrupt sources are a built-in mtime/mtimecmp timer, a software-interrupt bit and NUM_EXT_IRQ external lines.
- Sequences the mepc/mcause/mstatus CSR writes, stalls the pipeline, then redirects EX to the trap or return target.
- Replaces the fixed-width single-source controller.

Parameters:
XLEN, 64, datapath/CSR width (32 or 64)
NUM_EXT_IRQ, 4, external interrupt lines (1..16)
TIMER_DIV, 1, clk cycles per mtime increment (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
inst_i  in  32  instruction in ID
inst_addr_i  in  XLEN  PC of inst_i
jump_flag_i  in  1  EX taking a jump this cycle
jump_addr_i  in  XLEN  EX jump target
csr_mtvec  in  XLEN  current mtvec
csr_mepc  in  XLEN  current mepc
csr_mstatus  in  XLEN  current mstatus
csr_mie  in  XLEN  current mie
irq_ext_i  in  NUM_EXT_IRQ  level-sensitive external requests
tmr_we_i  in  1  timer register write strobe
tmr_addr_i  in  2  0=mtime, 1=mtimecmp, 2=msip
tmr_wdata_i  in  XLEN  timer write data
tmr_rdata_o  out  XLEN  timer read data (combinational on tmr_addr_i)
timer_irq_o  out  1  mtime >= mtimecmp
hold_flag_o  out  1  pipeline stall to ctrl
we_o  out  1  CSR write enable
waddr_o  out  12  CSR write address
data_o  out  XLEN  CSR write data
int_assert_o  out  1  one-cycle redirect pulse to EX
int_addr_o  out  XLEN  redirect target

Behaviour:
Reset:
- Clock is clk; reset rst is asynchronous, active-high.
- rst forces state IDLE, mtime=0, mtimecmp=all-ones, msip=0, and zeroes all registered outputs.
- Reset mid-sequence abandons the sequence with no further CSR writes.

Decode:
- ECALL=32'h00000073, EBREAK=32'h00100073, MRET=32'h30200073.
- CSR addresses: mstatus 0x300, mepc 0x341, mcause 0x342.
- mstatus bits: MIE=3, MPIE=7. mie bits: MSIE=3, MTIE=7, MEIE=11.

Pending and priority (evaluated in IDLE only):
- Pending: ext = |irq_ext_i & MEIE; sw = msip & MSIE; tmr = timer_irq_o & MTIE.
- Async is taken only when mstatus.MIE=1.
- Priority: ECALL/EBREAK > ext (lowest index wins) > sw > tmr > MRET.

Trap causes:
- ECALL: mcause 11. EBREAK: mcause 3.
- External line i: mcause MSB=1, code 16+i. Software: MSB=1, code 3. Timer: MSB=1, code 7.

Latched mepc:
- Sync trap: inst_addr_i.
- Async trap: jump_addr_i if jump_flag_i, else inst_addr_i.

FSM: IDLE -> MEPC -> MCAUSE -> MSTATUS -> ASSERT -> IDLE; MRET path IDLE -> MRET_ST -> ASSERT -> IDLE.
- A trigger sampled in IDLE at edge E0 moves the FSM to MEPC.
- Registered outputs, trap path:
  - cycle E0+1: we_o=1 to mepc.
  - E0+2: we_o=1 to mcause.
  - E0+3: we_o=1 to mstatus, data = csr_mstatus with MPIE<=MIE and MIE<=0.
  - E0+4: int_assert_o=1, int_addr_o=trap target.
- Registered outputs, MRET path:
  - E0+1: we_o=1 to mstatus, data with MIE<=MPIE and MPIE<=1.
  - E0+2: int_assert_o=1, int_addr_o=csr_mepc.
- Outside these cycles: we_o=0, waddr_o=0, data_o=0, int_assert_o=0, int_addr_o=0.

hold_flag_o:
- Combinational: high when state!=IDLE, or when a trigger is present in IDLE.
- Stays high through the int_assert_o cycle.

Timer:
- Prescaler counts 0..TIMER_DIV-1; mtime increments when the prescaler wraps.
- mtime wraps from all-ones to 0.
- A write to mtime in the same cycle as an increment: the write wins, and the prescaler clears.
- msip is wdata[0]. tmr_addr_i=3 reads 0; writes to it are ignored.
- Timer writes are accepted in any state and do not affect an in-flight sequence.
- Interrupt sources are level-sensitive. A deasserted source or a new source that appears during a sequence has no effect until IDLE.

Optional Feature:
CLINT_VECTORED_EN
- Defined: if csr_mtvec[1:0]==2'b01 and the trap is async, target = {mtvec[XLEN-1:2],2'b00} + 4*code. Otherwise target = {mtvec[XLEN-1:2],2'b00}.
- Undefined: target = {mtvec[XLEN-1:2],2'b00} always; mtvec[1:0] is ignored.

Test Plan:
1. ECALL at inst_addr_i=0x80000010, mtvec=0x80001000 -> writes mepc=0x80000010, mcause=11, mstatus MIE=0/MPIE=old MIE; int_assert_o with 0x80001000 four cycles after trigger; hold_flag_o high 5 cycles.
2. TIMER_DIV=4, mtimecmp=10, MIE=1, MTIE=1 -> timer_irq_o rises 40 cycles after reset; mcause={1,7}; mepc=jump_addr_i when jump_flag_i=1 at trigger.
3. irq_ext_i=4'b0110 plus msip=1, MEIE=MSIE=1 -> line 1 wins with mcause={1,17}; after MRET, mstatus MIE restored and int_addr_o=csr_mepc.
4. MIE=0 with all sources pending -> no trap and hold_flag_o=0. ECALL concurrent with pending ext irq -> ECALL taken (mcause 11).
5. Assert rst during the MCAUSE cycle -> outputs 0 immediately (asynchronously), no mstatus write, mtime=0, mtimecmp=all-ones.
6. CLINT_VECTORED_EN defined, mtvec=0x80001001, timer trap -> int_addr_o=0x8000101C. With the macro undefined -> 0x80001000.

Source files
------------

// File: rtl/clint_trap_ctrl_if.sv
// Core-side bundle for clint_trap_ctrl: ID/EX inputs, CSR snapshot, timer bus and CSR/redirect outputs.
interface clint_trap_ctrl_if #(
  parameter int XLEN        = 64,
  parameter int NUM_EXT_IRQ = 4
);
  logic [31:0]            inst_i;
  logic [XLEN-1:0]        inst_addr_i;
  logic                   jump_flag_i;
  logic [XLEN-1:0]        jump_addr_i;
  logic [XLEN-1:0]        csr_mtvec;
  logic [XLEN-1:0]        csr_mepc;
  logic [XLEN-1:0]        csr_mstatus;
  logic [XLEN-1:0]        csr_mie;
  logic [NUM_EXT_IRQ-1:0] irq_ext_i;
  logic                   tmr_we_i;
  logic [1:0]             tmr_addr_i;
  logic [XLEN-1:0]        tmr_wdata_i;
  logic [XLEN-1:0]        tmr_rdata_o;
  logic                   timer_irq_o;
  logic                   hold_flag_o;
  logic                   we_o;
  logic [11:0]            waddr_o;
  logic [XLEN-1:0]        data_o;
  logic                   int_assert_o;
  logic [XLEN-1:0]        int_addr_o;

  modport master (
    output inst_i, inst_addr_i, jump_flag_i, jump_addr_i,
    output csr_mtvec, csr_mepc, csr_mstatus, csr_mie, irq_ext_i,
    output tmr_we_i, tmr_addr_i, tmr_wdata_i,
    input  tmr_rdata_o, timer_irq_o, hold_flag_o, we_o, waddr_o, data_o,
    input  int_assert_o, int_addr_o
  );

  modport slave (
    input  inst_i, inst_addr_i, jump_flag_i, jump_addr_i,
    input  csr_mtvec, csr_mepc, csr_mstatus, csr_mie, irq_ext_i,
    input  tmr_we_i, tmr_addr_i, tmr_wdata_i,
    output tmr_rdata_o, timer_irq_o, hold_flag_o, we_o, waddr_o, data_o,
    output int_assert_o, int_addr_o
  );
endinterface

// File: rtl/clint_trap_ctrl.sv
// Machine-mode trap controller: mtime/mtimecmp/msip timer, trap arbitration, CSR write sequencing.
// Optional: define CLINT_VECTORED_EN for vectored async targets when mtvec[1:0]==2'b01.
module clint_trap_ctrl #(
  parameter int XLEN        = 64,
  parameter int NUM_EXT_IRQ = 4,
  parameter int TIMER_DIV   = 1
) (
  input logic              clk,
  input logic              rst,
  clint_trap_ctrl_if.slave bus
);
  localparam logic [31:0] ECALL     = 32'h00000073;
  localparam logic [31:0] EBREAK    = 32'h00100073;
  localparam logic [31:0] MRET      = 32'h30200073;
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam int          PW        = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_MEPC, S_MCAUSE, S_MSTATUS, S_MRET, S_ASSERT} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_mtime, r_mtimecmp;
  logic            r_msip;
  logic [PW-1:0]   r_presc;
  logic [XLEN-1:0] r_cause;
  logic            r_async;
  logic            r_we, r_int_assert;
  logic [11:0]     r_waddr;
  logic [XLEN-1:0] r_data, r_int_addr;

  logic            w_tick, w_timer_irq;
  logic            w_ext_pend, w_sw_pend, w_tmr_pend;
  logic            w_sync, w_async, w_mret, w_trig;
  logic [4:0]      w_ext_code, w_code;
  logic [XLEN-1:0] w_cause, w_mepc, w_base, w_target, w_mst_trap, w_mst_ret, w_rdata;
  logic            w_unused;

  // ---------------- timer ----------------
  assign w_tick      = (r_presc == PRESC_MAX);
  assign w_timer_irq = (r_mtime >= r_mtimecmp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc    <= '0;
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) r_mtime <= r_mtime + 1'b1;
      // mtime writes override a coincident tick and restart the prescaler
      if (bus.tmr_we_i) begin
        case (bus.tmr_addr_i)
          2'd0: begin
            r_mtime <= bus.tmr_wdata_i;
            r_presc <= '0;
          end
          2'd1:    r_mtimecmp <= bus.tmr_wdata_i;
          2'd2:    r_msip     <= bus.tmr_wdata_i[0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.tmr_addr_i)
      2'd0:    w_rdata = r_mtime;
      2'd1:    w_rdata = r_mtimecmp;
      2'd2:    w_rdata[0] = r_msip;
      default: w_rdata = '0;
    endcase
  end

  // ---------------- arbitration ----------------
  always_comb begin
    w_ext_code = 5'd16;
    for (int i = NUM_EXT_IRQ - 1; i >= 0; i--)
      if (bus.irq_ext_i[i]) w_ext_code = 5'(16 + i);
  end

  assign w_ext_pend = (|bus.irq_ext_i) & bus.csr_mie[11];
  assign w_sw_pend  = r_msip & bus.csr_mie[3];
  assign w_tmr_pend = w_timer_irq & bus.csr_mie[7];
  assign w_sync     = (bus.inst_i == ECALL) || (bus.inst_i == EBREAK);
  assign w_async    = bus.csr_mstatus[3] & (w_ext_pend | w_sw_pend | w_tmr_pend);
  assign w_mret     = (bus.inst_i == MRET);
  assign w_trig     = w_sync | w_async | w_mret;

  always_comb begin
    if (w_sync)          w_code = (bus.inst_i == ECALL) ? 5'd11 : 5'd3;
    else if (w_ext_pend) w_code = w_ext_code;
    else if (w_sw_pend)  w_code = 5'd3;
    else                 w_code = 5'd7;
    w_cause         = '0;
    w_cause[4:0]    = w_code;
    w_cause[XLEN-1] = ~w_sync;
  end

  assign w_mepc = (!w_sync && bus.jump_flag_i) ? bus.jump_addr_i : bus.inst_addr_i;

  always_comb begin
    w_mst_trap    = bus.csr_mstatus;
    w_mst_trap[7] = bus.csr_mstatus[3];
    w_mst_trap[3] = 1'b0;
    w_mst_ret     = bus.csr_mstatus;
    w_mst_ret[3]  = bus.csr_mstatus[7];
    w_mst_ret[7]  = 1'b1;
  end

  assign w_base = {bus.csr_mtvec[XLEN-1:2], 2'b00};
`ifdef CLINT_VECTORED_EN
  assign w_target = (bus.csr_mtvec[1:0] == 2'b01 && r_async)
                  ? w_base + {{(XLEN-7){1'b0}}, r_cause[4:0], 2'b00} : w_base;
`else
  assign w_target = w_base;
`endif
  assign w_unused = ^{bus.csr_mie, bus.csr_mtvec[1:0], r_async};

  // ---------------- sequencer ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cause      <= '0;
      r_async      <= 1'b0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_data       <= '0;
      r_int_assert <= 1'b0;
      r_int_addr   <= '0;
    end else begin
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_data       <= '0;
      r_int_assert <= 1'b0;
      r_int_addr   <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_sync || w_async) begin
            r_state <= S_MEPC;
            r_cause <= w_cause;
            r_async <= ~w_sync;
            r_we    <= 1'b1;
            r_waddr <= A_MEPC;
            r_data  <= w_mepc;
          end else if (w_mret) begin
            r_state <= S_MRET;
            r_we    <= 1'b1;
            r_waddr <= A_MSTATUS;
            r_data  <= w_mst_ret;
          end
        end
        S_MEPC: begin
          r_state <= S_MCAUSE;
          r_we    <= 1'b1;
          r_waddr <= A_MCAUSE;
          r_data  <= r_cause;
        end
        S_MCAUSE: begin
          r_state <= S_MSTATUS;
          r_we    <= 1'b1;
          r_waddr <= A_MSTATUS;
          r_data  <= w_mst_trap;
        end
        S_MSTATUS: begin
          r_state      <= S_ASSERT;
          r_int_assert <= 1'b1;
          r_int_addr   <= w_target;
        end
        S_MRET: begin
          r_state      <= S_ASSERT;
          r_int_assert <= 1'b1;
          r_int_addr   <= bus.csr_mepc;
        end
        S_ASSERT: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.tmr_rdata_o  = w_rdata;
  assign bus.timer_irq_o  = w_timer_irq;
  assign bus.hold_flag_o  = (r_state != S_IDLE) | w_trig;
  assign bus.we_o         = r_we;
  assign bus.waddr_o      = r_waddr;
  assign bus.data_o       = r_data;
  assign bus.int_assert_o = r_int_assert;
  assign bus.int_addr_o   = r_int_addr;
endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Self-checking bench for clint_trap_ctrl: directed scenarios plus randomized arbitration against a reference model.
module tb_clint_trap_ctrl;
  localparam int XLEN = 64;
  localparam int NIRQ = 4;
  localparam int DIV  = 4;
  localparam logic [31:0] ECALL  = 32'h00000073;
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] MRET   = 32'h30200073;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [63:0] ONES   = '1;

  typedef logic [142:0] snap_t;
  typedef logic [5:0][142:0] seq_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] cyc = '0;
  logic [63:0] m_wval = '0, m_wcyc = '0, m_cmp = ONES;
  logic        m_msip = 1'b0;

  clint_trap_ctrl_if #(.XLEN(XLEN), .NUM_EXT_IRQ(NIRQ)) bus();
  clint_trap_ctrl #(.XLEN(XLEN), .NUM_EXT_IRQ(NIRQ), .TIMER_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 64'd1;

  // mtime = last written value plus one per DIV edges since that write
  function automatic logic [63:0] exp_mtime();
    return m_wval + (cyc - m_wcyc) / 64'(DIV);
  endfunction

  function automatic snap_t obs();
    return {bus.hold_flag_o, bus.we_o, bus.waddr_o, bus.data_o, bus.int_assert_o, bus.int_addr_o};
  endfunction

  function automatic snap_t mk(logic h, logic w, logic [11:0] a, logic [63:0] d, logic ia, logic [63:0] ad);
    return {h, w, a, d, ia, ad};
  endfunction

  function automatic seq_t exp_trap(logic [63:0] mepc, logic [63:0] cause, logic [63:0] mst, logic [63:0] tgt);
    seq_t s;
    logic [63:0] m;
    m = mst; m[7] = mst[3]; m[3] = 1'b0;
    s[0] = mk(1'b1, 1'b1, 12'h341, mepc, 1'b0, 64'd0);
    s[1] = mk(1'b1, 1'b1, 12'h342, cause, 1'b0, 64'd0);
    s[2] = mk(1'b1, 1'b1, 12'h300, m, 1'b0, 64'd0);
    s[3] = mk(1'b1, 1'b0, 12'h000, 64'd0, 1'b1, tgt);
    s[4] = '0;
    s[5] = '0;
    return s;
  endfunction

  function automatic seq_t exp_mret(logic [63:0] mst, logic [63:0] mepc);
    seq_t s;
    logic [63:0] m;
    m = mst; m[3] = mst[7]; m[7] = 1'b1;
    s    = '0;
    s[0] = mk(1'b1, 1'b1, 12'h300, m, 1'b0, 64'd0);
    s[1] = mk(1'b1, 1'b0, 12'h000, 64'd0, 1'b1, mepc);
    return s;
  endfunction

  // 0 none, 1 sync trap, 2 async trap, 3 mret
  function automatic int model_kind(input logic [31:0] inst, input logic [3:0] irq, input logic [63:0] mie,
                                    input logic [63:0] mst, input logic msip, input logic tmr,
                                    output logic [63:0] cause);
    logic ext, sw, tp;
    int   lo;
    cause = '0;
    if (inst == ECALL)  begin cause = 64'd11; return 1; end
    if (inst == EBREAK) begin cause = 64'd3;  return 1; end
    ext = (irq != 4'd0) && mie[11];
    sw  = msip && mie[3];
    tp  = tmr && mie[7];
    if (mst[3] && (ext || sw || tp)) begin
      if (ext) begin
        lo = 0;
        while (lo < 3 && !irq[lo]) lo++;
        cause = {1'b1, 63'(16 + lo)};
      end else if (sw) cause = {1'b1, 63'd3};
      else             cause = {1'b1, 63'd7};
      return 2;
    end
    if (inst == MRET) return 3;
    return 0;
  endfunction

  task automatic tmr_write(input logic [1:0] a, input logic [63:0] d);
    bus.tmr_we_i = 1'b1; bus.tmr_addr_i = a; bus.tmr_wdata_i = d;
    @(posedge clk); #1;
    bus.tmr_we_i = 1'b0;
    case (a)
      2'd0: begin m_wval = d; m_wcyc = cyc; end
      2'd1: m_cmp = d;
      2'd2: m_msip = d[0];
      default: ;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    m_wval = '0; m_wcyc = cyc; m_cmp = ONES; m_msip = 1'b0;
  endtask

  // Records the six cycles following the trigger edge; sources are withdrawn after that edge.
  task automatic capture(output seq_t s);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        bus.inst_i = NOP; bus.csr_mie = '0; bus.irq_ext_i = 4'($urandom);
        #1;
      end
      s[k] = obs();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (obs() !== '0 || bus.timer_irq_o !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got %h irq=%b want 0", obs(), bus.timer_irq_o);
    end
    bus.tmr_addr_i = 2'd0; #1;
    checks++; if (bus.tmr_rdata_o !== 64'd0) begin errors++; $display("FAIL reset_mtime: got %h want 0", bus.tmr_rdata_o); end
    bus.tmr_addr_i = 2'd1; #1;
    checks++; if (bus.tmr_rdata_o !== ONES) begin errors++; $display("FAIL reset_mtimecmp: got %h want %h", bus.tmr_rdata_o, ONES); end
    bus.tmr_addr_i = 2'd2; #1;
    checks++; if (bus.tmr_rdata_o !== 64'd0) begin errors++; $display("FAIL reset_msip: got %h want 0", bus.tmr_rdata_o); end
    rst = 1'b0;
    m_wval = '0; m_wcyc = cyc; m_cmp = ONES; m_msip = 1'b0;
  endtask

  task automatic test_ecall();
    seq_t s, e;
    bus.csr_mstatus = 64'h8; bus.csr_mie = '0; bus.irq_ext_i = '0; bus.csr_mtvec = 64'h80001000;
    bus.inst_addr_i = 64'h80000010; bus.jump_flag_i = 1'b1; bus.jump_addr_i = 64'hDEAD0000;
    bus.inst_i = ECALL; #1;
    checks++; if (bus.hold_flag_o !== 1'b1) begin errors++; $display("FAIL ecall_hold0: got %b want 1", bus.hold_flag_o); end
    capture(s);
    e = exp_trap(64'h80000010, 64'd11, 64'h8, 64'h80001000);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (s[k] !== e[k]) begin errors++; $display("FAIL ecall_seq c%0d: got %h want %h", k + 1, s[k], e[k]); end
    end
  endtask

  task automatic test_ext_mret();
    seq_t s, e;
    bus.csr_mstatus = '0; bus.inst_i = NOP; bus.jump_flag_i = 1'b0;
    tmr_write(2'd2, 64'd1);
    bus.csr_mie = 64'h808; bus.irq_ext_i = 4'b0110; bus.inst_addr_i = 64'h80000100;
    bus.csr_mstatus = 64'h8; #1;
    checks++; if (bus.hold_flag_o !== 1'b1) begin errors++; $display("FAIL ext_hold0: got %b want 1", bus.hold_flag_o); end
    capture(s);
    e = exp_trap(64'h80000100, {1'b1, 63'd17}, 64'h8, 64'h80001000);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (s[k] !== e[k]) begin errors++; $display("FAIL ext_seq c%0d: got %h want %h", k + 1, s[k], e[k]); end
    end
    bus.csr_mstatus = 64'h80; bus.csr_mepc = 64'h80000100; bus.inst_i = MRET; #1;
    checks++; if (bus.hold_flag_o !== 1'b1) begin errors++; $display("FAIL mret_hold0: got %b want 1", bus.hold_flag_o); end
    capture(s);
    e = exp_mret(64'h80, 64'h80000100);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (s[k] !== e[k]) begin errors++; $display("FAIL mret_seq c%0d: got %h want %h", k + 1, s[k], e[k]); end
    end
    tmr_write(2'd2, 64'd0);
    bus.irq_ext_i = '0;
  endtask

  task automatic test_masked();
    seq_t s, e;
    bus.csr_mstatus = 64'h80; bus.inst_i = NOP; bus.csr_mie = '0;
    tmr_write(2'd2, 64'd1);
    tmr_write(2'd1, 64'd0);
    bus.csr_mie = 64'h888; bus.irq_ext_i = 4'hF; #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs() !== '0) begin errors++; $display("FAIL masked_idle c%0d: got %h want 0", k, obs()); end
      @(posedge clk); #1;
    end
    bus.csr_mstatus = 64'h8; bus.inst_i = ECALL; bus.inst_addr_i = 64'h80000600; #1;
    capture(s);
    e = exp_trap(64'h80000600, 64'd11, 64'h8, 64'h80001000);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (s[k] !== e[k]) begin errors++; $display("FAIL ecall_over_ext c%0d: got %h want %h", k + 1, s[k], e[k]); end
    end
    bus.csr_mstatus = '0; bus.irq_ext_i = '0;
    tmr_write(2'd1, ONES);
    tmr_write(2'd2, 64'd0);
  endtask

  task automatic test_timer_regs();
    bus.csr_mstatus = '0; bus.csr_mie = '0; bus.inst_i = NOP;
    tmr_write(2'd0, ONES);
    for (int n = 0; n < 10; n++) begin
      bus.tmr_addr_i = 2'd0; #1;
      checks++;
      if (bus.tmr_rdata_o !== exp_mtime()) begin errors++; $display("FAIL mtime_wrap n=%0d: got %h want %h", n, bus.tmr_rdata_o, exp_mtime()); end
      @(posedge clk); #1;
    end
    for (int ph = 0; ph < DIV; ph++) begin
      for (int w = 0; w < ph; w++) begin @(posedge clk); #1; end
      tmr_write(2'd0, 64'(ph * 1000));
      for (int n = 0; n < 6; n++) begin
        bus.tmr_addr_i = 2'd0; #1;
        checks++;
        if (bus.tmr_rdata_o !== exp_mtime()) begin errors++; $display("FAIL mtime_write ph=%0d n=%0d: got %h want %h", ph, n, bus.tmr_rdata_o, exp_mtime()); end
        @(posedge clk); #1;
      end
    end
    tmr_write(2'd3, 64'd123);
    bus.tmr_addr_i = 2'd3; #1;
    checks++; if (bus.tmr_rdata_o !== 64'd0) begin errors++; $display("FAIL addr3_read: got %h want 0", bus.tmr_rdata_o); end
    bus.tmr_addr_i = 2'd1; #1;
    checks++; if (bus.tmr_rdata_o !== m_cmp) begin errors++; $display("FAIL addr3_ignored: got %h want %h", bus.tmr_rdata_o, m_cmp); end
    tmr_write(2'd2, 64'hFF);
    bus.tmr_addr_i = 2'd2; #1;
    checks++; if (bus.tmr_rdata_o !== 64'd1) begin errors++; $display("FAIL msip_read: got %h want 1", bus.tmr_rdata_o); end
    tmr_write(2'd2, 64'd0);
  endtask

  task automatic test_random();
    seq_t s, e;
    logic [63:0] cause, mepc, tgt;
    logic [31:0] inst;
    int kind;
    for (int it = 0; it < 40; it++) begin
      bus.inst_i = NOP; bus.csr_mstatus = '0; bus.csr_mie = '0;
      tmr_write(2'd2, {63'd0, 1'($urandom)});
      tmr_write(2'd1, ($urandom_range(0, 1) == 1) ? 64'd0 : ONES);
      case ($urandom_range(0, 4))
        0:       inst = ECALL;
        1:       inst = EBREAK;
        2:       inst = MRET;
        3:       inst = NOP;
        default: inst = $urandom;
      endcase
      bus.inst_addr_i = {$urandom, $urandom};
      bus.jump_flag_i = 1'($urandom);
      bus.jump_addr_i = {$urandom, $urandom};
      bus.csr_mtvec   = {$urandom, $urandom};
      bus.csr_mepc    = {$urandom, $urandom};
      bus.csr_mstatus = {$urandom, $urandom};
      bus.csr_mie     = {$urandom, $urandom};
      bus.irq_ext_i   = 4'($urandom);
      bus.inst_i      = inst;
      #1;
      kind = model_kind(inst, bus.irq_ext_i, bus.csr_mie, bus.csr_mstatus, m_msip, exp_mtime() >= m_cmp, cause);
      checks++;
      if (bus.hold_flag_o !== (kind != 0)) begin errors++; $display("FAIL rand_hold it=%0d: got %b want %b", it, bus.hold_flag_o, kind != 0); end
      if (kind == 1 || kind == 2) begin
        mepc = (kind == 2 && bus.jump_flag_i) ? bus.jump_addr_i : bus.inst_addr_i;
        tgt  = {bus.csr_mtvec[63:2], 2'b00};
`ifdef CLINT_VECTORED_EN
        if (kind == 2 && bus.csr_mtvec[1:0] == 2'b01) tgt = tgt + 64'(cause[4:0]) * 64'd4;
`endif
        e = exp_trap(mepc, cause, bus.csr_mstatus, tgt);
        capture(s);
      end else if (kind == 3) begin
        e = exp_mret(bus.csr_mstatus, bus.csr_mepc);
        capture(s);
      end else begin
        e = '0;
        for (int k = 0; k < 6; k++) begin @(posedge clk); #1; s[k] = obs(); end
      end
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (s[k] !== e[k]) begin errors++; $display("FAIL rand_seq it=%0d kind=%0d c%0d: got %h want %h", it, kind, k + 1, s[k], e[k]); end
      end
    end
    bus.inst_i = NOP; bus.csr_mstatus = '0; bus.csr_mie = '0; bus.irq_ext_i = '0;
    tmr_write(2'd1, ONES);
    tmr_write(2'd2, 64'd0);
  endtask

  task automatic test_vectored();
    seq_t s, e;
    logic [63:0] tgt;
    bus.csr_mstatus = '0; bus.csr_mie = 64'h80; bus.csr_mtvec = 64'h80001001;
    bus.jump_flag_i = 1'b0; bus.inst_addr_i = 64'h80000400; bus.inst_i = NOP; bus.irq_ext_i = '0;
    tmr_write(2'd1, 64'd0);
    bus.csr_mstatus = 64'h8; #1;
    checks++; if (bus.hold_flag_o !== 1'b1) begin errors++; $display("FAIL vec_hold0: got %b want 1", bus.hold_flag_o); end
`ifdef CLINT_VECTORED_EN
    tgt = 64'h8000101C;
`else
    tgt = 64'h80001000;
`endif
    capture(s);
    e = exp_trap(64'h80000400, {1'b1, 63'd7}, 64'h8, tgt);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (s[k] !== e[k]) begin errors++; $display("FAIL vec_seq c%0d: got %h want %h", k + 1, s[k], e[k]); end
    end
    bus.csr_mstatus = '0;
    tmr_write(2'd1, ONES);
    bus.csr_mtvec = 64'h80001000;
  endtask

  task automatic test_timer();
    seq_t s, e;
    logic [63:0] t0;
    int n;
    bus.inst_i = NOP; bus.irq_ext_i = '0; bus.csr_mstatus = 64'h8; bus.csr_mie = 64'h80;
    bus.jump_flag_i = 1'b1; bus.jump_addr_i = 64'h80000200; bus.inst_addr_i = 64'h80000300;
    bus.csr_mtvec = 64'h80001000;
    do_reset();
    t0 = cyc;
    tmr_write(2'd1, 64'd10);
    n = 0;
    while (!bus.timer_irq_o && n < 60) begin
      bus.tmr_addr_i = 2'd0; #1;
      checks++;
      if (bus.tmr_rdata_o !== exp_mtime()) begin errors++; $display("FAIL timer_count n=%0d: got %h want %h", n, bus.tmr_rdata_o, exp_mtime()); end
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bus.timer_irq_o !== 1'b1 || (cyc - t0) !== 64'd40) begin
      errors++; $display("FAIL timer_rise: got irq=%b at %0d cycles want irq=1 at 40", bus.timer_irq_o, cyc - t0);
    end
    checks++; if (bus.hold_flag_o !== 1'b1) begin errors++; $display("FAIL timer_hold0: got %b want 1", bus.hold_flag_o); end
    capture(s);
    e = exp_trap(64'h80000200, {1'b1, 63'd7}, 64'h8, 64'h80001000);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (s[k] !== e[k]) begin errors++; $display("FAIL timer_seq c%0d: got %h want %h", k + 1, s[k], e[k]); end
    end
    tmr_write(2'd1, ONES);
  endtask

  task automatic test_reset_mid();
    bus.csr_mstatus = 64'h8; bus.csr_mie = '0; bus.irq_ext_i = '0; bus.jump_flag_i = 1'b0;
    bus.inst_addr_i = 64'h80000500; bus.inst_i = ECALL; #1;
    @(posedge clk); #1; bus.inst_i = NOP;
    @(posedge clk); #1;
    checks++;
    if (bus.we_o !== 1'b1 || bus.waddr_o !== 12'h342) begin
      errors++; $display("FAIL rmid_mcause: got we=%b addr=%h want we=1 addr=342", bus.we_o, bus.waddr_o);
    end
    #2; rst = 1'b1; #1;
    checks++; if (obs() !== '0) begin errors++; $display("FAIL rmid_async: got %h want 0", obs()); end
    bus.tmr_addr_i = 2'd0; #1;
    checks++; if (bus.tmr_rdata_o !== 64'd0) begin errors++; $display("FAIL rmid_mtime: got %h want 0", bus.tmr_rdata_o); end
    bus.tmr_addr_i = 2'd1; #1;
    checks++; if (bus.tmr_rdata_o !== ONES) begin errors++; $display("FAIL rmid_mtimecmp: got %h want %h", bus.tmr_rdata_o, ONES); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    m_wval = '0; m_wcyc = cyc; m_cmp = ONES; m_msip = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (obs() !== '0) begin errors++; $display("FAIL rmid_quiet c%0d: got %h want 0", k, obs()); end
    end
  endtask

  initial begin
    bus.inst_i = NOP; bus.inst_addr_i = '0; bus.jump_flag_i = 1'b0; bus.jump_addr_i = '0;
    bus.csr_mtvec = 64'h80001000; bus.csr_mepc = '0; bus.csr_mstatus = '0; bus.csr_mie = '0;
    bus.irq_ext_i = '0; bus.tmr_we_i = 1'b0; bus.tmr_addr_i = 2'd0; bus.tmr_wdata_i = '0;
    test_reset();
    test_ecall();
    test_ext_mret();
    test_masked();
    test_timer_regs();
    test_random();
    test_vectored();
    test_timer();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
